// File: rtl/rf_sched_pkg.sv
// Shared sizing and slot-index type for the register-file writeback scheduler.
package rf_sched_pkg;
  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int NREG = 2 ** AW;

  typedef logic slot_idx_t;

  localparam slot_idx_t SLOT0 = 1'b0;
  localparam slot_idx_t SLOT1 = 1'b1;
endpackage

// File: rtl/rf_wb_slot.sv
// One-entry writeback holding register with an age bit (1 = younger than the
// entry held in the other slot).
module rf_wb_slot #(
  parameter int DW = rf_sched_pkg::DW,
  parameter int AW = rf_sched_pkg::AW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cap_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  input  logic          young_i,
  input  logic          grant_i,
  input  logic          other_gnt_i,
  output logic          full_o,
  output logic          young_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o
);
  logic          full_q;
  logic          young_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q  <= 1'b0;
      young_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (cap_i) begin
      full_q  <= 1'b1;
      young_q <= young_i;
      addr_q  <= addr_i;
      data_q  <= data_i;
    end else begin
      if (grant_i)
        full_q <= 1'b0;
      // Once the older entry has drained, this one is no longer the younger.
      if (grant_i || other_gnt_i)
        young_q <= 1'b0;
    end
  end

  assign full_o  = full_q;
  assign young_o = young_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: two holding slots share one registered register-file
// write port; round-robin on distinct addresses, oldest-first on a collision.
module rf_wb_arbiter #(
  parameter int DW = rf_sched_pkg::DW,
  parameter int AW = rf_sched_pkg::AW
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [AW-1:0]     in0_addr,
  input  logic [DW-1:0]     in0_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [AW-1:0]     in1_addr,
  input  logic [DW-1:0]     in1_data,
  output logic              rf_we,
  output logic [AW-1:0]     rf_wa,
  output logic [DW-1:0]     rf_wd,
  output logic [2**AW-1:0]  busy,
  output logic [7:0]        wr_count
);
  import rf_sched_pkg::slot_idx_t;

  localparam int NREG = 2 ** AW;

  logic [1:0]      in_valid;
  logic [AW-1:0]   in_addr   [2];
  logic [DW-1:0]   in_data   [2];
  logic [1:0]      full;
  logic [1:0]      young;
  logic [1:0]      gnt;
  logic [1:0]      cap;
  logic [1:0]      ready;
  logic [1:0]      cap_young;
  logic [AW-1:0]   slot_addr [2];
  logic [DW-1:0]   slot_data [2];
  slot_idx_t       rr_q;
  slot_idx_t       pick;
  logic            rf_we_q;
  logic [AW-1:0]   rf_wa_q;
  logic [DW-1:0]   rf_wd_q;
  logic [7:0]      wr_count_q;
  logic [7:0]      wr_count_d;
  logic [NREG-1:0] busy_mask;

  assign in_valid   = {in1_valid, in0_valid};
  assign in_addr[0] = in0_addr;
  assign in_addr[1] = in1_addr;
  assign in_data[0] = in0_data;
  assign in_data[1] = in1_data;
  assign in0_ready  = ready[0];
  assign in1_ready  = ready[1];

  // A capture is younger if the other slot still holds an entry afterwards;
  // simultaneous captures leave slot 0 as the older one.
  assign cap_young[0] = full[1] & ~gnt[1];
  assign cap_young[1] = (full[0] & ~gnt[0]) | cap[0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      assign ready[gi] = ~full[gi] | gnt[gi];
      // Writes to r0 are accepted but dropped here.
      assign cap[gi]   = in_valid[gi] & ready[gi] & (in_addr[gi] != '0);

      rf_wb_slot #(
        .DW (DW),
        .AW (AW)
      ) u_slot (
        .clk         (clk),
        .rstn        (rstn),
        .cap_i       (cap[gi]),
        .addr_i      (in_addr[gi]),
        .data_i      (in_data[gi]),
        .young_i     (cap_young[gi]),
        .grant_i     (gnt[gi]),
        .other_gnt_i (gnt[1-gi]),
        .full_o      (full[gi]),
        .young_o     (young[gi]),
        .addr_o      (slot_addr[gi]),
        .data_o      (slot_data[gi])
      );
    end
  endgenerate

  always_comb begin
    gnt  = 2'b00;
    pick = rr_q;
    if (full == 2'b11) begin
      if (slot_addr[0] == slot_addr[1])
        pick = young[0] ? rf_sched_pkg::SLOT1 : rf_sched_pkg::SLOT0;
      gnt[pick] = 1'b1;
    end else begin
      gnt = full;
    end
  end

  assign wr_count_d = (rf_we_q && wr_count_q != 8'hFF) ? wr_count_q + 8'd1 : wr_count_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q       <= rf_sched_pkg::SLOT0;
      rf_we_q    <= 1'b0;
      rf_wa_q    <= '0;
      rf_wd_q    <= '0;
      wr_count_q <= '0;
    end else begin
      if (full == 2'b11)
        rr_q <= ~pick;
      rf_we_q <= |gnt;
      if (|gnt) begin
        rf_wa_q <= gnt[1] ? slot_addr[1] : slot_addr[0];
        rf_wd_q <= gnt[1] ? slot_data[1] : slot_data[0];
      end
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < 2; i++)
      if (full[i])
        busy_mask[slot_addr[i]] = 1'b1;
    if (rf_we_q)
      busy_mask[rf_wa_q] = 1'b1;
    busy_mask[0] = 1'b0;
  end

  assign rf_we    = rf_we_q;
  assign rf_wa    = rf_wa_q;
  assign rf_wd    = rf_wd_q;
  assign busy     = busy_mask;
  assign wr_count = wr_count_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, single write, contention, age
// ordering, r0 discard, mid-operation reset and counter saturation.
module tb_rf_wb_arbiter;
  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in0_valid = 1'b0;
  logic          in0_ready;
  logic [AW-1:0] in0_addr = '0;
  logic [DW-1:0] in0_data = '0;
  logic          in1_valid = 1'b0;
  logic          in1_ready;
  logic [AW-1:0] in1_addr = '0;
  logic [DW-1:0] in1_data = '0;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [7:0]    busy;
  logic [7:0]    wr_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_addr  (in0_addr),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_addr  (in1_addr),
    .in1_data  (in1_data),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .busy      (busy),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) tick();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", rf_we); end
    n_checks++; if (rf_wa !== 3'd0) begin n_fail++; $display("FAIL reset_wa: got %0d want 0", rf_wa); end
    n_checks++; if (rf_wd !== 8'h00) begin n_fail++; $display("FAIL reset_wd: got %h want 00", rf_wd); end
    n_checks++; if (busy !== 8'h00) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (wr_count !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", wr_count); end
    rstn = 1'b1;
    tick();
    n_checks++; if (in0_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rdy0: got %b want 1", in0_ready); end
    n_checks++; if (in1_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rdy1: got %b want 1", in1_ready); end
    $display("reset: released, ready=%b%b", in1_ready, in0_ready);
  endtask

  task automatic test_single();
    in0_valid = 1'b1; in0_addr = 3'd3; in0_data = 8'h5A;
    tick();
    in0_valid = 1'b0;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL single_we_cap: got %b want 0", rf_we); end
    n_checks++; if (busy !== 8'h08) begin n_fail++; $display("FAIL single_busy_cap: got %b want 00001000", busy); end
    tick();
    n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", rf_we); end
    n_checks++; if (rf_wa !== 3'd3) begin n_fail++; $display("FAIL single_wa: got %0d want 3", rf_wa); end
    n_checks++; if (rf_wd !== 8'h5A) begin n_fail++; $display("FAIL single_wd: got %h want 5a", rf_wd); end
    n_checks++; if (busy !== 8'h08) begin n_fail++; $display("FAIL single_busy_out: got %b want 00001000", busy); end
    tick();
    exp_cnt = exp_cnt + 1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL single_we_end: got %b want 0", rf_we); end
    n_checks++; if (busy !== 8'h00) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
    n_checks++; if (wr_count !== 8'(exp_cnt)) begin n_fail++; $display("FAIL single_cnt: got %0d want %0d", wr_count, exp_cnt); end
    $display("single: r3=5a issued, wr_count=%0d", wr_count);
  endtask

  task automatic test_contend();
    logic [6:0] exp_we = 7'b0111110;
    logic [6:0] exp_r0 = 7'b1110101;
    logic [6:0] exp_r1 = 7'b1111010;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    in0_valid = 1'b1; in0_addr = 3'd1; in0_data = 8'h11;
    in1_valid = 1'b1; in1_addr = 3'd2; in1_data = 8'h22;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k == 3) begin in0_valid = 1'b0; in1_valid = 1'b0; end
      wa = (k % 2 == 1) ? 3'd1 : 3'd2;
      wd = (k % 2 == 1) ? 8'h11 : 8'h22;
      n_checks++; if (rf_we !== exp_we[k]) begin n_fail++; $display("FAIL contend_we[%0d]: got %b want %b", k, rf_we, exp_we[k]); end
      n_checks++; if ({in1_ready, in0_ready} !== {exp_r1[k], exp_r0[k]}) begin n_fail++; $display("FAIL contend_rdy[%0d]: got %b%b want %b%b", k, in1_ready, in0_ready, exp_r1[k], exp_r0[k]); end
      if (exp_we[k]) begin
        n_checks++; if (rf_wa !== wa || rf_wd !== wd) begin n_fail++; $display("FAIL contend_wr[%0d]: got r%0d=%h want r%0d=%h", k, rf_wa, rf_wd, wa, wd); end
      end
      $display("contend[%0d]: we=%b wa=%0d wd=%h ready=%b%b", k, rf_we, rf_wa, rf_wd, in1_ready, in0_ready);
    end
    exp_cnt = exp_cnt + 5;
    n_checks++; if (wr_count !== 8'(exp_cnt)) begin n_fail++; $display("FAIL contend_cnt: got %0d want %0d", wr_count, exp_cnt); end
  endtask

  task automatic test_same_addr();
    in1_valid = 1'b1; in1_addr = 3'd5; in1_data = 8'hAA;
    tick();
    in1_valid = 1'b0;
    in0_valid = 1'b1; in0_addr = 3'd5; in0_data = 8'hBB;
    n_checks++; if (busy !== 8'h20) begin n_fail++; $display("FAIL same_busy: got %b want 00100000", busy); end
    tick();
    in0_valid = 1'b0;
    n_checks++; if (rf_we !== 1'b1 || rf_wa !== 3'd5 || rf_wd !== 8'hAA) begin n_fail++; $display("FAIL same_first: got we=%b r%0d=%h want we=1 r5=aa", rf_we, rf_wa, rf_wd); end
    n_checks++; if (busy !== 8'h20) begin n_fail++; $display("FAIL same_busy2: got %b want 00100000", busy); end
    tick();
    n_checks++; if (rf_we !== 1'b1 || rf_wa !== 3'd5 || rf_wd !== 8'hBB) begin n_fail++; $display("FAIL same_second: got we=%b r%0d=%h want we=1 r5=bb", rf_we, rf_wa, rf_wd); end
    tick();
    exp_cnt = exp_cnt + 2;
    n_checks++; if (rf_we !== 1'b0 || busy !== 8'h00) begin n_fail++; $display("FAIL same_idle: got we=%b busy=%b want 0/0", rf_we, busy); end
    n_checks++; if (wr_count !== 8'(exp_cnt)) begin n_fail++; $display("FAIL same_cnt: got %0d want %0d", wr_count, exp_cnt); end
    $display("same_addr: r5 aa then bb, wr_count=%0d", wr_count);
  endtask

  task automatic test_age();
    // Steer rr to slot 1, then collide on r6: the older slot 0 must win.
    in0_valid = 1'b1; in0_addr = 3'd1; in0_data = 8'h11;
    in1_valid = 1'b1; in1_addr = 3'd2; in1_data = 8'h22;
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    tick();
    n_checks++; if (rf_wa !== 3'd1) begin n_fail++; $display("FAIL age_rr0: got r%0d want r1", rf_wa); end
    tick();
    n_checks++; if (rf_wa !== 3'd2) begin n_fail++; $display("FAIL age_rr1: got r%0d want r2", rf_wa); end
    in0_valid = 1'b1; in0_addr = 3'd6; in0_data = 8'h60;
    in1_valid = 1'b1; in1_addr = 3'd6; in1_data = 8'h61;
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    n_checks++; if (busy !== 8'h40 || rf_we !== 1'b0) begin n_fail++; $display("FAIL age_cap: got busy=%b we=%b want 01000000/0", busy, rf_we); end
    tick();
    n_checks++; if (rf_we !== 1'b1 || rf_wd !== 8'h60) begin n_fail++; $display("FAIL age_first: got we=%b wd=%h want 1/60", rf_we, rf_wd); end
    tick();
    n_checks++; if (rf_we !== 1'b1 || rf_wd !== 8'h61) begin n_fail++; $display("FAIL age_second: got we=%b wd=%h want 1/61", rf_we, rf_wd); end
    tick();
    exp_cnt = exp_cnt + 4;
    n_checks++; if (wr_count !== 8'(exp_cnt)) begin n_fail++; $display("FAIL age_cnt: got %0d want %0d", wr_count, exp_cnt); end
    $display("age: r6 60 then 61, wr_count=%0d", wr_count);
  endtask

  task automatic test_zero();
    in0_valid = 1'b1; in0_addr = 3'd0; in0_data = 8'hFF;
    n_checks++; if (in0_ready !== 1'b1) begin n_fail++; $display("FAIL zero_rdy: got %b want 1", in0_ready); end
    tick();
    in0_valid = 1'b0;
    n_checks++; if (in0_ready !== 1'b1 || busy !== 8'h00) begin n_fail++; $display("FAIL zero_slot: got rdy=%b busy=%b want 1/0", in0_ready, busy); end
    tick();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL zero_we: got %b want 0", rf_we); end
    tick();
    n_checks++; if (wr_count !== 8'(exp_cnt)) begin n_fail++; $display("FAIL zero_cnt: got %0d want %0d", wr_count, exp_cnt); end
    $display("zero: r0 write dropped, wr_count=%0d", wr_count);
  endtask

  task automatic test_reset_mid();
    in0_valid = 1'b1; in0_addr = 3'd3; in0_data = 8'h33;
    in1_valid = 1'b1; in1_addr = 3'd4; in1_data = 8'h44;
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    tick();
    n_checks++; if (rf_we !== 1'b1 || busy !== 8'h18) begin n_fail++; $display("FAIL rmid_pre: got we=%b busy=%b want 1/00011000", rf_we, busy); end
    #2 rstn = 1'b0;
    #1;
    exp_cnt = 0;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rmid_we: got %b want 0", rf_we); end
    n_checks++; if (busy !== 8'h00) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_checks++; if (wr_count !== 8'd0) begin n_fail++; $display("FAIL rmid_cnt: got %0d want 0", wr_count); end
    #2 rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (rf_we !== 1'b0 || busy !== 8'h00) begin n_fail++; $display("FAIL rmid_after[%0d]: got we=%b busy=%b want 0/0", k, rf_we, busy); end
    end
    $display("reset_mid: held writes discarded");
  endtask

  task automatic test_saturate();
    int n_we = 0;
    int n_stall = 0;
    in0_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      in0_addr = AW'((i % 7) + 1);
      in0_data = 8'(i);
      if (in0_ready !== 1'b1) n_stall++;
      tick();
      if (rf_we === 1'b1) n_we++;
      if (i == 100) begin
        n_checks++; if (rf_wa !== 3'd2 || rf_wd !== 8'd99) begin n_fail++; $display("FAIL sat_mid: got r%0d=%0d want r2=99", rf_wa, rf_wd); end
      end
    end
    in0_valid = 1'b0;
    repeat (2) begin
      tick();
      if (rf_we === 1'b1) n_we++;
    end
    n_checks++; if (n_stall != 0) begin n_fail++; $display("FAIL sat_stall: got %0d stalls want 0", n_stall); end
    n_checks++; if (n_we != 260) begin n_fail++; $display("FAIL sat_writes: got %0d want 260", n_we); end
    n_checks++; if (wr_count !== 8'd255) begin n_fail++; $display("FAIL sat_cnt: got %0d want 255", wr_count); end
    $display("saturate: %0d writes issued, wr_count=%0d", n_we, wr_count);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contend();
    test_same_addr();
    test_age();
    test_zero();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
